// File: rtl/xtop_run_ctrl_if.sv
// xtop parallel register-file port.
// The master (run controller) drives the address, write enable and write data.
// The slave (xtop) returns the read data one cycle after the address.
//   par_addr : register index
//   par_we   : write strobe
//   par_in   : write data
//   par_out  : read data, one-cycle latency
interface xtop_run_ctrl_if #(
    parameter int unsigned REGF_ADDR_W = 4,
    parameter int unsigned DATA_W      = 32
);
    logic [REGF_ADDR_W-1:0] par_addr;
    logic                   par_we;
    logic [DATA_W-1:0]      par_in;
    logic [DATA_W-1:0]      par_out;

    modport master (
        output par_addr,
        output par_we,
        output par_in,
        input  par_out
    );

    modport slave (
        input  par_addr,
        input  par_we,
        input  par_in,
        output par_out
    );
endinterface

// File: rtl/xtop_run_ctrl.sv
// Sequencer that launches one picoVersat computation through the xtop parallel
// register-file port.
// Flow: write op_a/op_b/op_code to R1-R3, write R0=1, poll R0 until the firmware
// clears it, then read R[RES_ADDR]. A watchdog aborts the run after TIMEOUT poll cycles.
//   clk, rst           : clock, asynchronous active-high reset
//   start              : launch request, only sampled when idle
//   op_a, op_b, op_code: operands, latched on an accepted start
//   busy               : high outside IDLE
//   done               : one-cycle completion pulse
//   timeout            : run was aborted (valid with done, held until next start)
//   result             : R[RES_ADDR] of the last successful run
//   cycles             : poll cycles used by the last run
//   par                : register-file port (master side)
module xtop_run_ctrl #(
    parameter int unsigned REGF_ADDR_W = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RES_ADDR    = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] op_code,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  cycles,
    xtop_run_ctrl_if.master   par
);

    localparam logic [REGF_ADDR_W-1:0] ResIdx     = REGF_ADDR_W'(RES_ADDR);
    localparam logic [CNT_W-1:0]       TimeoutCnt = CNT_W'(TIMEOUT);

    typedef enum logic [3:0] {
        StIdle, StWrA, StWrB, StWrOp, StGo, StPoll, StRdRes, StRdCap, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [DATA_W-1:0] op_code_q, op_code_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= '0;
            timeout_q <= 1'b0;
            result_q  <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_code_q <= op_code_d;
            timeout_q <= timeout_d;
            result_q  <= result_d;
            cycles_q  <= cycles_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_code_d    = op_code_q;
        timeout_d    = timeout_q;
        result_d     = result_q;
        cycles_d     = cycles_q;
        par.par_addr = '0;
        par.par_we   = 1'b0;
        par.par_in   = '0;
        busy         = (state_q != StIdle);
        done         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_a_d    = op_a;
                    op_b_d    = op_b;
                    op_code_d = op_code;
                    timeout_d = 1'b0;
                    cycles_d  = '0;
                    state_d   = StWrA;
                end
            end
            StWrA: begin
                par.par_addr = REGF_ADDR_W'(1);
                par.par_we   = 1'b1;
                par.par_in   = op_a_q;
                state_d      = StWrB;
            end
            StWrB: begin
                par.par_addr = REGF_ADDR_W'(2);
                par.par_we   = 1'b1;
                par.par_in   = op_b_q;
                state_d      = StWrOp;
            end
            StWrOp: begin
                par.par_addr = REGF_ADDR_W'(3);
                par.par_we   = 1'b1;
                par.par_in   = op_code_q;
                state_d      = StGo;
            end
            StGo: begin
                par.par_we = 1'b1;
                par.par_in = DATA_W'(1);
                state_d    = StPoll;
            end
            StPoll: begin
                cycles_d = cycles_q + CNT_W'(1);
                // cycles_q == 0 marks the first poll cycle, whose read data is still stale.
                if (cycles_q != '0 && par.par_out == '0) begin
                    state_d = StRdRes;
                end else if (cycles_d == TimeoutCnt) begin
                    timeout_d = 1'b1;
                    result_d  = '0;
                    state_d   = StDone;
                end
            end
            StRdRes: begin
                par.par_addr = ResIdx;
                state_d      = StRdCap;
            end
            StRdCap: begin
                par.par_addr = ResIdx;
                result_d     = par.par_out;
                state_d      = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign timeout = timeout_q;
    assign result  = result_q;
    assign cycles  = cycles_q;

endmodule

// File: doc/xtop_run_ctrl.md
# xtop_run_ctrl

Hardware sequencer that drives the xtop parallel register-file port (`par_addr`/`par_we`/`par_in`/`par_out`) in place of a host, so the PS/2 calculator front-end can launch one picoVersat computation per request. On `start` it loads operands into R1–R3 and writes R0=1 to release the firmware. It then polls R0 until the firmware clears it, reads the result register and reports completion with a cycle count. A watchdog aborts runs that never finish.

## Interface
- `REGF_ADDR_W`, 4: register-file address width; must match xtop.
- `DATA_W`, 32: data width; must match xtop.
- `RES_ADDR`, 4: register index read back as the result.
- `CNT_W`, 16: width of the cycle counter.
- `TIMEOUT`, 65535: maximum number of POLL cycles before abort; must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W−1.

- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: launch request; sampled only in IDLE.
- `op_a` in DATA_W: operand written to R1.
- `op_b` in DATA_W: operand written to R2.
- `op_code` in DATA_W: operation selector written to R3.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `timeout` out 1: set with `done` when the run was aborted; held until the next accepted `start`.
- `result` out DATA_W: R[RES_ADDR] from the last successful run.
- `cycles` out CNT_W: POLL cycles used by the last run.
- `par_addr` out REGF_ADDR_W: to xtop `par_addr`.
- `par_we` out 1: to xtop `par_we`.
- `par_in` out DATA_W: to xtop `par_in`.
- `par_out` in DATA_W: from xtop `par_out`.

## Operation
- States: IDLE, WR_A, WR_B, WR_OP, GO, POLL, RD_RES, RD_CAP, DONE.
- IDLE drives `par_addr`=0, `par_we`=0, `par_in`=0. When `start`=1, it latches `op_a`/`op_b`/`op_code`, clears `timeout` and `cycles`, and moves to WR_A.
- The write states each last exactly one cycle, with `par_we`=1:
  - WR_A: addr 1, data = latched `op_a`.
  - WR_B: addr 2, data = latched `op_b`.
  - WR_OP: addr 3, data = latched `op_code`.
  - GO: addr 0, data = 1.
- POLL: addr 0, `par_we`=0.
  - The register-file read has one-cycle latency, so `par_out` is ignored in the first POLL cycle.
  - From the second POLL cycle on, `par_out`==0 moves to RD_RES.
  - `cycles` increments on every POLL cycle, including the one in which zero is seen.
  - If R0 is still nonzero in the cycle where `cycles` reaches TIMEOUT, the block moves to DONE with `timeout`←1 and `result`←0.
- RD_RES: addr RES_ADDR, `par_we`=0.
- RD_CAP: addr RES_ADDR; `result`←`par_out` at the end of the cycle.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `par_*` outputs are decoded from the state register and latched operands only. There is no combinational path from `start`, `op_*` or `par_out` to any output.
- A `start` asserted while `busy` is ignored, not queued. `start` held high in IDLE after DONE launches a new run.
- `cycles` never wraps; TIMEOUT is reached before overflow.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `timeout`=0, `result`=0, `cycles`=0, `par_addr`=0, `par_we`=0, `par_in`=0.
- Assertion of `rst` mid-run forces IDLE immediately and drops `par_we` asynchronously. The firmware is not stopped; the system must reset xtop alongside this block.
- Cycle numbering, with `start` sampled in IDLE at cycle 0:
  - WR_A 1, WR_B 2, WR_OP 3, GO 4.
  - POLL from cycle 5.
  - If R0 reads 0 in the first checked cycle (6): RD_RES 7, RD_CAP 8, DONE 9 (`done` high), and `cycles`=2.
- General: `done` occurs 7 + n cycles after `start`, where n is the final `cycles` value.
- Timeout: `done` occurs 5 + TIMEOUT cycles after `start`, with `cycles`=TIMEOUT.
- `result`, `cycles` and `timeout` are valid when `done`=1 and stable until the next accepted `start`.

## Test plan
- Normal run:
  - Stimulus: behavioural regfile model with one-cycle read latency; firmware model clears R0 20 cycles after the R0=1 write and sets R4=0x0000_002A; `start` with `op_a`=5, `op_b`=7, `op_code`=2.
  - Required: R1/R2/R3 = 5/7/2 written in order, `done` pulse, `result`=0x2A, `timeout`=0, `cycles` matching the model delay.
- Minimum latency:
  - Stimulus: model clears R0 before the first checked POLL cycle.
  - Required: `done` in cycle 9 after `start`, `cycles`=2.
- Timeout:
  - Stimulus: TIMEOUT=64; model never clears R0.
  - Required: `done` at start+69, `timeout`=1, `result`=0, `cycles`=64, with no RD_RES access to RES_ADDR.
- Start while busy:
  - Stimulus: pulse `start` with new operands during POLL.
  - Required: ignored; the first run's operands are the only ones written, and exactly one `done` is produced.
- Reset mid-run:
  - Stimulus: assert `rst` during WR_B.
  - Required: `par_we`=0 the same cycle and all outputs at reset values; a following `start` completes a normal run.
- Back-to-back:
  - Stimulus: `start` held high.
  - Required: second run begins the cycle after DONE; `timeout` and `cycles` are cleared at relaunch; two `done` pulses.
